// File: rtl/glue_pkg.sv
// Shared types and constants for the 68000 bus-cycle glue logic.
package glue_pkg;

    typedef enum logic [2:0] {
        REG_ROM,
        REG_RAM,
        REG_IO,
        REG_UNMAPPED,
        REG_CPUSPACE
    } region_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT,
        ST_ACK,
        ST_FAULT
    } state_e;

    localparam logic [3:0] NIB_ROM = 4'h0;
    localparam logic [3:0] NIB_RAM = 4'h1;
    localparam logic [3:0] NIB_IO  = 4'hF;
    localparam logic [2:0] FC_CPU  = 3'b111;

    // CPU-space cycles carry no meaningful address, so fc overrides the nibble.
    function automatic region_e decode_region(input logic [2:0] fc, input logic [3:0] nib);
        region_e r;
        if (fc == FC_CPU) begin
            r = REG_CPUSPACE;
        end else begin
            case (nib)
                NIB_ROM: r = REG_ROM;
                NIB_RAM: r = REG_RAM;
                NIB_IO:  r = REG_IO;
                default: r = REG_UNMAPPED;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/wait_counter.sv
// 8-bit loadable down-counter; load has priority, decrement saturates at zero.
// Count updates one edge after load/dec; o_zero is decoded from the count register.
module wait_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/bus_cycle_ctl.sv
// 68000 bus-cycle controller: region decode, chip selects, wait states and DTACK/VPA/BERR.
// Enables assert one edge after AS low; acknowledge after the region wait; all outputs registered.
module bus_cycle_ctl
    import glue_pkg::*;
#(
    parameter int unsigned ROM_WAIT   = 2,
    parameter int unsigned RAM_WAIT   = 1,
    parameter int unsigned IO_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        as_n,
    input  logic        read,
    input  logic [2:0]  fc,
    input  logic [15:0] phys_addr,
    input  logic        io_dtack_n,
    output logic        rom_enable_n,
    output logic        ram_enable_n,
    output logic        io_enable_n,
    output logic        dtack_n,
    output logic        vpa_n,
    output logic        berr_n
);

    localparam logic [7:0] ROM_LOAD = 8'(ROM_WAIT - 1);
    localparam logic [7:0] RAM_LOAD = 8'(RAM_WAIT - 1);
    localparam logic [7:0] IO_LOAD  = 8'(IO_TIMEOUT - 1);

    state_e     r_state;
    state_e     w_state_nxt;
    region_e    r_region;
    region_e    w_region_nxt;
    region_e    w_addr_region;
    logic       r_armed;
    logic       w_load;
    logic [7:0] w_load_val;
    logic       w_dec;
    logic       w_cnt_zero;
    logic       w_unused;

    logic r_rom_n, r_ram_n, r_io_n, r_dtack_n, r_vpa_n, r_berr_n;
    logic w_rom_n, w_ram_n, w_io_n, w_dtack_n, w_vpa_n, w_berr_n;

    assign w_addr_region = decode_region(fc, phys_addr[15:12]);
    assign w_unused      = ^phys_addr[11:0];

    wait_counter #(.WIDTH(8)) u_wait_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_cnt_zero)
    );

    // DECODE doubles as the first wait cycle so a wait of W acknowledges W edges after the enable.
    always_comb begin
        w_state_nxt  = r_state;
        w_region_nxt = r_region;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_dec        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_armed && !as_n) begin
                    w_state_nxt  = ST_DECODE;
                    w_region_nxt = w_addr_region;
                    // A ROM write behaves exactly like an unmapped access.
                    if (w_addr_region == REG_ROM && !read) begin
                        w_region_nxt = REG_UNMAPPED;
                    end
                    w_load = 1'b1;
                    case (w_addr_region)
                        REG_ROM: w_load_val = ROM_LOAD;
                        REG_RAM: w_load_val = RAM_LOAD;
                        REG_IO:  w_load_val = IO_LOAD;
                        default: w_load_val = '0;
                    endcase
                end
            end
            ST_DECODE: begin
                if (as_n) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    case (r_region)
                        REG_ROM, REG_RAM: begin
                            if (w_cnt_zero) begin
                                w_state_nxt = ST_ACK;
                            end else begin
                                w_state_nxt = ST_WAIT;
                                w_dec       = 1'b1;
                            end
                        end
                        REG_IO: begin
                            w_state_nxt = ST_WAIT;
                            w_dec       = 1'b1;
                        end
                        REG_CPUSPACE: w_state_nxt = ST_ACK;
                        default:      w_state_nxt = ST_FAULT;
                    endcase
                end
            end
            ST_WAIT: begin
                if (as_n) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_region == REG_IO) begin
                    if (!io_dtack_n) begin
                        w_state_nxt = ST_ACK;
                    end else if (w_cnt_zero) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_dec = 1'b1;
                    end
                end else if (w_cnt_zero) begin
                    w_state_nxt = ST_ACK;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_ACK, ST_FAULT: begin
                if (as_n) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rom_n   = 1'b1;
        w_ram_n   = 1'b1;
        w_io_n    = 1'b1;
        w_dtack_n = 1'b1;
        w_vpa_n   = 1'b1;
        w_berr_n  = 1'b1;
        if (w_state_nxt == ST_DECODE || w_state_nxt == ST_WAIT || w_state_nxt == ST_ACK) begin
            case (w_region_nxt)
                REG_ROM: w_rom_n = 1'b0;
                REG_RAM: w_ram_n = 1'b0;
                REG_IO:  w_io_n  = 1'b0;
                default: ;
            endcase
        end
        if (w_state_nxt == ST_ACK) begin
            if (w_region_nxt == REG_CPUSPACE) begin
                w_vpa_n = 1'b0;
            end else begin
                w_dtack_n = 1'b0;
            end
        end
        if (w_state_nxt == ST_FAULT) begin
            w_berr_n = 1'b0;
        end
    end

    // r_armed keeps a cycle that was cut by reset from restarting until AS has been seen high.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_region  <= REG_UNMAPPED;
            r_armed   <= 1'b0;
            r_rom_n   <= 1'b1;
            r_ram_n   <= 1'b1;
            r_io_n    <= 1'b1;
            r_dtack_n <= 1'b1;
            r_vpa_n   <= 1'b1;
            r_berr_n  <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_region  <= w_region_nxt;
            r_armed   <= r_armed | as_n;
            r_rom_n   <= w_rom_n;
            r_ram_n   <= w_ram_n;
            r_io_n    <= w_io_n;
            r_dtack_n <= w_dtack_n;
            r_vpa_n   <= w_vpa_n;
            r_berr_n  <= w_berr_n;
        end
    end

    assign rom_enable_n = r_rom_n;
    assign ram_enable_n = r_ram_n;
    assign io_enable_n  = r_io_n;
    assign dtack_n      = r_dtack_n;
    assign vpa_n        = r_vpa_n;
    assign berr_n       = r_berr_n;

endmodule

// File: tb/tb_bus_cycle_ctl.sv
// Directed bench for bus_cycle_ctl with a cycle-timing model checked on every falling edge.
module tb_bus_cycle_ctl;

    localparam int ROM_W = 2;
    localparam int RAM_W = 1;
    localparam int IO_T  = 64;

    localparam int C_ROM   = 0;
    localparam int C_RAM   = 1;
    localparam int C_IO    = 2;
    localparam int C_FAULT = 3;
    localparam int C_CPU   = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        as_n;
    logic        read;
    logic [2:0]  fc;
    logic [15:0] phys_addr;
    logic        io_dtack_n;
    logic        rom_enable_n, ram_enable_n, io_enable_n, dtack_n, vpa_n, berr_n;
    logic [5:0]  outs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bus_cycle_ctl #(
        .ROM_WAIT   (ROM_W),
        .RAM_WAIT   (RAM_W),
        .IO_TIMEOUT (IO_T)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .as_n         (as_n),
        .read         (read),
        .fc           (fc),
        .phys_addr    (phys_addr),
        .io_dtack_n   (io_dtack_n),
        .rom_enable_n (rom_enable_n),
        .ram_enable_n (ram_enable_n),
        .io_enable_n  (io_enable_n),
        .dtack_n      (dtack_n),
        .vpa_n        (vpa_n),
        .berr_n       (berr_n)
    );

    assign outs = {rom_enable_n, ram_enable_n, io_enable_n, dtack_n, vpa_n, berr_n};

    // Model: k counts edges since the edge that sampled AS low; outputs follow from k and the region.
    bit         m_valid  = 1'b0;
    bit         m_active = 1'b0;
    bit         m_armed  = 1'b0;
    int         m_k      = 0;
    int         m_cls    = 0;
    int         m_ack_k  = 0;
    logic [5:0] m_exp    = 6'b111111;

    function automatic int classify(input logic [2:0] f, input logic [15:0] a, input logic rd);
        if (f == 3'b111) return C_CPU;
        if (a[15:12] == 4'h0) return rd ? C_ROM : C_FAULT;
        if (a[15:12] == 4'h1) return C_RAM;
        if (a[15:12] == 4'hF) return C_IO;
        return C_FAULT;
    endfunction

    function automatic logic [5:0] model_outs(input bit act, input int cls, input int k, input int ack_k);
        logic [5:0] e;
        e = 6'b111111;
        if (act) begin
            case (cls)
                C_ROM: begin e[5] = 1'b0; e[2] = !(k >= 1 + ROM_W); end
                C_RAM: begin e[4] = 1'b0; e[2] = !(k >= 1 + RAM_W); end
                C_IO: begin
                    if (ack_k != 0) begin
                        e[3] = 1'b0;
                        e[2] = 1'b0;
                    end else if (k >= 1 + IO_T) begin
                        e[0] = 1'b0;
                    end else begin
                        e[3] = 1'b0;
                    end
                end
                C_FAULT: e[0] = !(k >= 2);
                default: e[1] = !(k >= 2);
            endcase
        end
        return e;
    endfunction

    always @(posedge clk) begin
        m_valid = 1'b1;
        if (!reset_n) begin
            m_active = 1'b0;
            m_armed  = 1'b0;
        end else begin
            if (m_active) begin
                if (as_n) begin
                    m_active = 1'b0;
                end else begin
                    m_k++;
                    if (m_cls == C_IO && m_ack_k == 0 && !io_dtack_n && m_k >= 3 && m_k <= IO_T + 1)
                        m_ack_k = m_k;
                end
            end else if (m_armed && !as_n) begin
                m_active = 1'b1;
                m_k      = 1;
                m_cls    = classify(fc, phys_addr, read);
                m_ack_k  = 0;
            end
            if (as_n) m_armed = 1'b1;
        end
        m_exp = model_outs(m_active, m_cls, m_k, m_ack_k);
    end

    always @(negedge clk) begin
        if (m_valid) begin
            n_tests++;
            if (outs !== m_exp) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t got=%b expected=%b (rom,ram,io,dtack,vpa,berr)",
                         $time, outs, m_exp);
            end
        end
    end

    task automatic check(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start(input logic [15:0] a, input logic rd, input logic [2:0] f);
        phys_addr = a;
        read      = rd;
        fc        = f;
        as_n      = 1'b0;
    endtask

    task automatic end_cycle(input string nm);
        as_n = 1'b1;
        tick();
        check(nm, &outs, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        as_n       = 1'b1;
        read       = 1'b1;
        fc         = 3'b101;
        phys_addr  = 16'h0000;
        io_dtack_n = 1'b1;
        run(3);
        check("reset_outputs", &outs, 1'b1);
        reset_n = 1'b1;
        run(1);

        // ROM read: enable at edge 1, DTACK at edge 3.
        start(16'h0123, 1'b1, 3'b101);
        tick(); check("rom_en_e1", rom_enable_n, 1'b0); check("rom_dtack_e1", dtack_n, 1'b1);
        tick(); check("rom_dtack_e2", dtack_n, 1'b1);
        tick(); check("rom_dtack_e3", dtack_n, 1'b0);
        tick();
        end_cycle("rom_release");

        // Back-to-back RAM write.
        start(16'h1FFF, 1'b0, 3'b101);
        tick(); check("ram_en_e1", ram_enable_n, 1'b0); check("ram_dtack_e1", dtack_n, 1'b1);
        tick(); check("ram_dtack_e2", dtack_n, 1'b0);
        end_cycle("ram_release");

        // ROM write is a bus error with no enable.
        start(16'h0000, 1'b0, 3'b101);
        tick(); check("romwr_e1_idle", &outs, 1'b1);
        tick(); check("romwr_berr_e2", berr_n, 1'b0); check("romwr_no_en", rom_enable_n, 1'b1);
        end_cycle("romwr_release");

        // I/O acknowledged by the device.
        start(16'hF000, 1'b1, 3'b101);
        run(5); check("io_en_e5", io_enable_n, 1'b0); check("io_dtack_e5", dtack_n, 1'b1);
        io_dtack_n = 1'b0;
        tick(); check("io_dtack_e6", dtack_n, 1'b0); check("io_en_e6", io_enable_n, 1'b0);
        io_dtack_n = 1'b1;
        end_cycle("io_release");

        // I/O timeout.
        start(16'hF000, 1'b0, 3'b101);
        run(64); check("io_to_en_e64", io_enable_n, 1'b0); check("io_to_berr_e64", berr_n, 1'b1);
        tick(); check("io_to_berr_e65", berr_n, 1'b0); check("io_to_en_e65", io_enable_n, 1'b1);
        run(2);
        end_cycle("io_to_release");

        // Device acknowledge on the expiry edge wins over the timeout.
        start(16'hF000, 1'b1, 3'b101);
        run(64);
        io_dtack_n = 1'b0;
        tick(); check("io_race_dtack", dtack_n, 1'b0); check("io_race_berr", berr_n, 1'b1);
        io_dtack_n = 1'b1;
        end_cycle("io_race_release");

        // CPU space gets VPA regardless of address.
        start(16'h5000, 1'b1, 3'b111);
        tick(); check("cpu_e1_idle", &outs, 1'b1);
        tick(); check("cpu_vpa_e2", vpa_n, 1'b0); check("cpu_dtack_e2", dtack_n, 1'b1);
        end_cycle("cpu_release");

        // Unmapped address.
        start(16'h5000, 1'b1, 3'b101);
        run(2); check("unmap_berr_e2", berr_n, 1'b0);
        end_cycle("unmap_release");

        // Abort a ROM cycle before acknowledge.
        start(16'h0123, 1'b1, 3'b101);
        run(2);
        as_n = 1'b1;
        tick(); check("abort_e3", &outs, 1'b1);
        run(4); check("abort_no_dtack", dtack_n, 1'b1);

        // Reset during WAIT: no acknowledge afterwards even with AS and device DTACK low.
        start(16'hF000, 1'b1, 3'b101);
        run(3);
        reset_n = 1'b0;
        tick(); check("reset_mid", &outs, 1'b1);
        run(1);
        reset_n    = 1'b1;
        io_dtack_n = 1'b0;
        run(8); check("no_ack_after_reset", &outs, 1'b1);
        io_dtack_n = 1'b1;
        as_n       = 1'b1;
        run(1);
        start(16'h1000, 1'b1, 3'b101);
        run(2); check("recover_dtack", dtack_n, 1'b0);
        end_cycle("recover_release");

        run(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
